mips32_instr_encoder: RTL and testbench
=======================================

Name: mips32_instr_encoder

Overview:
- Sequential MIPS32 instruction encoder and loader; the encode direction of the control-unit decode path.
- Accepts symbolic instruction requests (op, register fields, immediate or target) over a valid/ready handshake.
- Packs each request into a 32-bit MIPS word and writes it sequentially into instruction memory, starting at a programmable base word address.
- Used by the SOC boot/test loader to fill instruction memory before the core is released.

Parameters:
ADDR_W, 10, instruction-memory word-address width; highest address is 2^ADDR_W-1.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse: load base_addr, clear counters, enter ACTIVE
base_addr  input  ADDR_W  first word address written
finish  input  1  one-cycle pulse: end session (ACTIVE -> DONE)
req_valid  input  1  request present
req_ready  output  1  encoder accepts request this cycle
req_op  input  4  symbolic op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8 BNE, 9 JUMP; 10-15 invalid
req_rs  input  5  rs field
req_rt  input  5  rt field
req_rd  input  5  rd field (R-type only)
req_imm  input  16  immediate/offset (I-type only)
req_target  input  26  jump target (JUMP only)
imem_we  output  1  instruction-memory write strobe
imem_addr  output  ADDR_W  write word address
imem_wdata  output  32  encoded instruction
busy  output  1  high in ACTIVE
done  output  1  high in DONE
full  output  1  sticky: last address written
inv_op  output  1  sticky: an invalid req_op was accepted
num_written  output  ADDR_W+1  words written this session

Behaviour:
- Reset: state IDLE; req_ready, imem_we, busy, done, full, inv_op = 0; imem_addr, imem_wdata, num_written = 0; write pointer = 0.
- States:
  - IDLE: start -> ACTIVE.
  - ACTIVE: finish or full -> DONE.
  - DONE: start -> ACTIVE.
  - start is ignored in ACTIVE. finish is ignored outside ACTIVE.
- On start: wptr <= base_addr; num_written, full, inv_op cleared.
- req_ready = (state == ACTIVE) && !full && !finish. Combinational; independent of req_valid.
- Accept when req_valid && req_ready.
- Latency 1: the cycle after accept, imem_we = 1 for exactly one cycle, imem_addr = wptr at accept, imem_wdata = encoded word. Back-to-back accepts give back-to-back writes; throughput 1/cycle.
- Encoding:
  - R-type {6'h00, rs, rt, rd, 5'b0, funct}; funct ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A.
  - I-type {opc, rs, rt, imm}; opc LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05.
  - J-type {opc 0x02, target}.
  - Fields not used by an op are ignored.
- Invalid op (10-15):
  - Request is still accepted (handshake completes).
  - No write occurs; wptr and num_written unchanged.
  - inv_op set sticky until the next start.
- wptr increments only on a valid accept. num_written increments on each imem_we.
- Boundary: accepting a valid request with wptr == 2^ADDR_W-1 sets full the next cycle alongside that write. State then goes to DONE. No wrap-around; wptr holds.
- finish in the same cycle as a pending accept: req_ready is already low, so no accept occurs. A write already issued from a prior accept completes normally.
- imem_addr and imem_wdata hold their last values when imem_we = 0.
- rst mid-session: return to IDLE next edge. Any pending write is dropped (imem_we = 0).

Decomposition:
- Shared package/header:
  - symbolic op codes 0-9;
  - MIPS opcode/funct constants (shared with the control-unit opcode header);
  - state encoding IDLE/ACTIVE/DONE.
- One combinational sub-module, mips32_word_pack: maps (op, rs, rt, rd, imm, target) to {word[31:0], valid}.
- The top level holds the FSM, write pointer, output register and flags.

Test Plan:
- start with base_addr=0; ADD rs=1 rt=2 rd=3 -> one cycle later imem_we=1, imem_addr=0, imem_wdata=0x00221820; num_written=1.
- Back-to-back LW rs=29 rt=8 imm=0x0004, BEQ rs=4 rt=5 imm=0xFFFF, JUMP target=0x0100000 -> writes 0x8FA80004 @0, 0x1085FFFF @1, 0x08100000 @2 on consecutive cycles.
- req_op=12 between two ADDs -> inv_op=1; only 2 writes, at addresses 0 and 1; num_written=2.
- ADDR_W=10, base_addr=1022, three valid requests -> writes at 1022 and 1023; full=1, done=1; third request never sees req_ready=1.
- finish while req_valid is held -> req_ready=0 that cycle; done=1 next cycle. Then start with base_addr=5 -> counters cleared, next write at 5.
- rst asserted the cycle after an accept -> imem_we stays 0; all outputs return to reset values next edge.

Source files
------------

// File: rtl/mips32_instr_encoder_pkg.sv
// Shared definitions for the MIPS32 instruction encoder: symbolic ops,
// MIPS opcode/funct constants, FSM state encoding and the request payload.
package mips32_instr_encoder_pkg;

  localparam int unsigned OP_W     = 4;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned IMM_W    = 16;
  localparam int unsigned TARGET_W = 26;
  localparam int unsigned WORD_W   = 32;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SLT  = 4'd4,
    OP_LW   = 4'd5,
    OP_SW   = 4'd6,
    OP_BEQ  = 4'd7,
    OP_BNE  = 4'd8,
    OP_JUMP = 4'd9
  } op_e;

  // Opcode and funct values match the control-unit decode tables.
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0]     op;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    rd;
    logic [IMM_W-1:0]    imm;
    logic [TARGET_W-1:0] target;
  } req_t;

endpackage

// File: rtl/mips32_word_pack.sv
// Combinational packer: symbolic request -> 32-bit MIPS word plus a flag
// saying whether the op code was one of the ten supported ops.
module mips32_word_pack
  import mips32_instr_encoder_pkg::*;
(
  input  req_t              req,
  output logic [WORD_W-1:0] word,
  output logic              valid
);

  always_comb begin
    word  = '0;
    valid = 1'b1;
    case (req.op)
      OP_ADD:  word = {OPC_RTYPE, req.rs, req.rt, req.rd, 5'b0, FN_ADD};
      OP_SUB:  word = {OPC_RTYPE, req.rs, req.rt, req.rd, 5'b0, FN_SUB};
      OP_AND:  word = {OPC_RTYPE, req.rs, req.rt, req.rd, 5'b0, FN_AND};
      OP_OR:   word = {OPC_RTYPE, req.rs, req.rt, req.rd, 5'b0, FN_OR};
      OP_SLT:  word = {OPC_RTYPE, req.rs, req.rt, req.rd, 5'b0, FN_SLT};
      OP_LW:   word = {OPC_LW,  req.rs, req.rt, req.imm};
      OP_SW:   word = {OPC_SW,  req.rs, req.rt, req.imm};
      OP_BEQ:  word = {OPC_BEQ, req.rs, req.rt, req.imm};
      OP_BNE:  word = {OPC_BNE, req.rs, req.rt, req.imm};
      OP_JUMP: word = {OPC_J, req.target};
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips32_instr_encoder.sv
// Session-based instruction loader: accepts symbolic requests, encodes them
// and writes consecutive instruction-memory words from a programmable base.
module mips32_instr_encoder
  import mips32_instr_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic                finish,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [OP_W-1:0]     req_op,
  input  logic [REG_W-1:0]    req_rs,
  input  logic [REG_W-1:0]    req_rt,
  input  logic [REG_W-1:0]    req_rd,
  input  logic [IMM_W-1:0]    req_imm,
  input  logic [TARGET_W-1:0] req_target,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [WORD_W-1:0]   imem_wdata,
  output logic                busy,
  output logic                done,
  output logic                full,
  output logic                inv_op,
  output logic [ADDR_W:0]     num_written
);

  state_e              state;
  state_e              state_next;
  logic [ADDR_W-1:0]   wptr;
  req_t                req;
  logic [WORD_W-1:0]   pack_word;
  logic                pack_valid;
  logic                accept;
  logic                wr_ok;
  logic                at_top;
  logic                session_start;

  assign req = '{op: req_op, rs: req_rs, rt: req_rt, rd: req_rd,
                 imm: req_imm, target: req_target};

  mips32_word_pack u_pack (
    .req   (req),
    .word  (pack_word),
    .valid (pack_valid)
  );

  // Handshake is combinational so finish blocks an accept in the same cycle.
  assign req_ready     = (state == ST_ACTIVE) && !full && !finish;
  assign accept        = req_valid && req_ready;
  assign wr_ok         = accept && pack_valid;
  assign at_top        = (wptr == {ADDR_W{1'b1}});
  assign session_start = start && (state != ST_ACTIVE);

  assign busy = (state == ST_ACTIVE);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Filling the last word ends the session at the same edge that sets full.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_ACTIVE;
      ST_ACTIVE: if (finish || full || (wr_ok && at_top)) state_next = ST_DONE;
      ST_DONE:   if (start) state_next = ST_ACTIVE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr        <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      full        <= 1'b0;
      inv_op      <= 1'b0;
      num_written <= '0;
    end else begin
      imem_we <= wr_ok;
      if (wr_ok) begin
        imem_addr   <= wptr;
        imem_wdata  <= pack_word;
        num_written <= num_written + (ADDR_W+1)'(1);
        if (at_top) full <= 1'b1;
        else        wptr <= wptr + ADDR_W'(1);
      end
      if (accept && !pack_valid) inv_op <= 1'b1;
      if (session_start) begin
        wptr        <= base_addr;
        num_written <= '0;
        full        <= 1'b0;
        inv_op      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mips32_instr_encoder.sv
// Directed bench for mips32_instr_encoder with hand-computed MIPS words.
module tb_mips32_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic        finish;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [4:0]  req_rs;
  logic [4:0]  req_rt;
  logic [4:0]  req_rd;
  logic [15:0] req_imm;
  logic [25:0] req_target;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        busy;
  logic        done;
  logic        full;
  logic        inv_op;
  logic [10:0] num_written;

  int checks   = 0;
  int failures = 0;

  mips32_instr_encoder #(.ADDR_W(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .finish      (finish),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_rs      (req_rs),
    .req_rt      (req_rt),
    .req_rd      (req_rd),
    .req_imm     (req_imm),
    .req_target  (req_target),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .busy        (busy),
    .done        (done),
    .full        (full),
    .inv_op      (inv_op),
    .num_written (num_written)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
    req_op = op; req_rs = rs; req_rt = rt; req_rd = rd; req_imm = imm; req_target = tgt;
  endtask

  task automatic begin_session(input logic [9:0] base);
    base_addr = base;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic end_session();
    finish = 1'b1;
    tick();
    finish = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; finish = 1'b0; req_valid = 1'b0;
    set_req(4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_we",    32'(imem_we), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_num",   32'(num_written), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);

    // Single ADD at base 0
    begin_session(10'd0);
    check("start_busy",  32'(busy), 32'd1);
    check("start_ready", 32'(req_ready), 32'd1);
    set_req(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("add_we",   32'(imem_we), 32'd1);
    check("add_addr", 32'(imem_addr), 32'd0);
    check("add_data", imem_wdata, 32'h0022_1820);
    check("add_num",  32'(num_written), 32'd1);
    tick();
    check("add_we_off",   32'(imem_we), 32'd0);
    check("add_addr_hold", 32'(imem_addr), 32'd0);
    check("add_data_hold", imem_wdata, 32'h0022_1820);

    // finish ends the session
    finish = 1'b1;
    #1;
    check("fin_ready", 32'(req_ready), 32'd0);
    tick();
    finish = 1'b0;
    check("fin_done", 32'(done), 32'd1);
    check("fin_busy", 32'(busy), 32'd0);

    // Back-to-back LW, BEQ, JUMP
    begin_session(10'd0);
    req_valid = 1'b1;
    set_req(4'd5, 5'd29, 5'd8, 5'd0, 16'h0004, 26'd0);
    tick();
    check("lw_we",   32'(imem_we), 32'd1);
    check("lw_addr", 32'(imem_addr), 32'd0);
    check("lw_data", imem_wdata, 32'h8FA8_0004);
    set_req(4'd7, 5'd4, 5'd5, 5'd0, 16'hFFFF, 26'd0);
    tick();
    check("beq_we",   32'(imem_we), 32'd1);
    check("beq_addr", 32'(imem_addr), 32'd1);
    check("beq_data", imem_wdata, 32'h1085_FFFF);
    set_req(4'd9, 5'd0, 5'd0, 5'd0, 16'd0, 26'h010_0000);
    tick();
    req_valid = 1'b0;
    check("j_we",   32'(imem_we), 32'd1);
    check("j_addr", 32'(imem_addr), 32'd2);
    check("j_data", imem_wdata, 32'h0810_0000);
    tick();
    check("b2b_num", 32'(num_written), 32'd3);
    check("b2b_we",  32'(imem_we), 32'd0);
    end_session();

    // Invalid op sandwiched between ADD and SUB
    begin_session(10'd0);
    req_valid = 1'b1;
    set_req(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
    tick();
    set_req(4'd12, 5'd1, 5'd2, 5'd3, 16'h1234, 26'd0);
    #1;
    check("inv_ready", 32'(req_ready), 32'd1);
    tick();
    check("inv_we",  32'(imem_we), 32'd0);
    check("inv_flag", 32'(inv_op), 32'd1);
    set_req(4'd1, 5'd5, 5'd6, 5'd7, 16'd0, 26'd0);
    tick();
    req_valid = 1'b0;
    check("sub_addr", 32'(imem_addr), 32'd1);
    check("sub_data", imem_wdata, 32'h00A6_3822);
    tick();
    check("inv_num",    32'(num_written), 32'd2);
    check("inv_sticky", 32'(inv_op), 32'd1);
    end_session();

    // Top-of-memory boundary with base 1022
    begin_session(10'd1022);
    check("top_inv_clr", 32'(inv_op), 32'd0);
    req_valid = 1'b1;
    set_req(4'd6, 5'd2, 5'd3, 5'd0, 16'h0010, 26'd0);
    tick();
    check("top_addr0", 32'(imem_addr), 32'd1022);
    check("top_data0", imem_wdata, 32'hAC43_0010);
    check("top_full0", 32'(full), 32'd0);
    tick();
    check("top_addr1", 32'(imem_addr), 32'd1023);
    check("top_we1",   32'(imem_we), 32'd1);
    check("top_full1", 32'(full), 32'd1);
    check("top_done",  32'(done), 32'd1);
    check("top_ready", 32'(req_ready), 32'd0);
    tick();
    check("top_we2",   32'(imem_we), 32'd0);
    check("top_num",   32'(num_written), 32'd2);
    check("top_addr2", 32'(imem_addr), 32'd1023);
    req_valid = 1'b0;

    // finish while a request is held
    begin_session(10'd0);
    check("restart_full", 32'(full), 32'd0);
    check("restart_num",  32'(num_written), 32'd0);
    set_req(4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0);
    req_valid = 1'b1;
    finish = 1'b1;
    #1;
    check("finv_ready", 32'(req_ready), 32'd0);
    tick();
    finish = 1'b0;
    req_valid = 1'b0;
    check("finv_we",   32'(imem_we), 32'd0);
    check("finv_done", 32'(done), 32'd1);
    check("finv_num",  32'(num_written), 32'd0);

    // New session at base 5; start while active is ignored
    begin_session(10'd5);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("b5_addr", 32'(imem_addr), 32'd5);
    check("b5_num",  32'(num_written), 32'd1);
    begin_session(10'd100);
    check("ign_busy", 32'(busy), 32'd1);
    check("ign_num",  32'(num_written), 32'd1);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("ign_addr", 32'(imem_addr), 32'd6);

    // Reset coinciding with an accept drops the write
    req_valid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 1'b0;
    check("mrst_we",    32'(imem_we), 32'd0);
    check("mrst_busy",  32'(busy), 32'd0);
    check("mrst_num",   32'(num_written), 32'd0);
    check("mrst_addr",  32'(imem_addr), 32'd0);
    check("mrst_wdata", imem_wdata, 32'd0);
    check("mrst_ready", 32'(req_ready), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
